// File: rtl/mp_acc_seq.sv
// mp_acc_seq
//   Sequencer that owns the shared two-lane packed-add datapath. It streams
//   operand-word pairs through the datapath into two 32-bit accumulators and
//   can finish with a single mode_3 fold pass before presenting the result.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   start_i, len_i      command strobe and beat count (accepted when idle)
//   mode3_i, keep_i     run fold pass after last beat / keep accumulators
//   abort_i             cancel the in-flight command (RUN or FOLD only)
//   busy_o              high whenever a command is in flight or unacknowledged
//   op_valid_i/ready_o  operand beat handshake, op_data_i lanes 0/1
//   add_a_o, add_b_o    datapath operands, add_mode3_o datapath mode select
//   add_sum_i           datapath sums (combinational return path)
//   res_valid_o/ready_i result handshake, res_data_o lanes 0/1
module mp_acc_seq #(
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      len_i,
  input  logic                  mode3_i,
  input  logic                  keep_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic [1:0][31:0]      op_data_i,
  output logic [1:0][31:0]      add_a_o,
  output logic [1:0][31:0]      add_b_o,
  output logic                  add_mode3_o,
  input  logic [1:0][31:0]      add_sum_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [1:0][31:0]      res_data_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             mode3_q;
  logic [1:0][31:0] acc;

  // Control state and accumulators; the accumulators only ever take a
  // datapath sum or zero, the sequencer itself does no arithmetic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      mode3_q <= 1'b0;
      acc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            cnt     <= len_i;
            mode3_q <= mode3_i;
            if (!keep_i) acc <= '0;
            if (len_i != '0)  state <= RUN;
            else if (mode3_i) state <= FOLD;
            else              state <= DONE;
          end
        end
        RUN: begin
          if (abort_i) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
          end else if (op_valid_i) begin
            acc <= add_sum_i;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= mode3_q ? FOLD : DONE;
          end
        end
        FOLD: begin
          if (abort_i) begin
            state <= IDLE;
            acc   <= '0;
          end else begin
            acc   <= add_sum_i;
            state <= DONE;
          end
        end
        DONE: begin
          if (res_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from the registered state; datapath is quiet outside
  // RUN/FOLD, and an abort withholds ready so no beat is consumed.
  always_comb begin
    busy_o      = (state != IDLE);
    op_ready_o  = 1'b0;
    add_a_o     = '0;
    add_b_o     = '0;
    add_mode3_o = 1'b0;
    res_valid_o = 1'b0;
    res_data_o  = '0;
    case (state)
      RUN: begin
        op_ready_o = !abort_i;
        add_a_o    = acc;
        add_b_o    = op_data_i;
      end
      FOLD: begin
        add_a_o     = acc;
        add_mode3_o = 1'b1;
      end
      DONE: begin
        res_valid_o = 1'b1;
        res_data_o  = acc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mp_acc_seq.sv
module tb_mp_acc_seq;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic [15:0]       len_i = '0;
  logic              mode3_i = 1'b0;
  logic              keep_i = 1'b0;
  logic              abort_i = 1'b0;
  logic              busy_o;
  logic              op_valid_i = 1'b0;
  logic              op_ready_o;
  logic [1:0][31:0]  op_data_i = '0;
  logic [1:0][31:0]  add_a_o;
  logic [1:0][31:0]  add_b_o;
  logic              add_mode3_o;
  logic [1:0][31:0]  add_sum_i;
  logic              res_valid_o;
  logic              res_ready_i = 1'b0;
  logic [1:0][31:0]  res_data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mp_acc_seq #(.CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
    .mode3_i(mode3_i), .keep_i(keep_i), .abort_i(abort_i), .busy_o(busy_o),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_data_i(op_data_i),
    .add_a_o(add_a_o), .add_b_o(add_b_o), .add_mode3_o(add_mode3_o),
    .add_sum_i(add_sum_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o)
  );

  // External datapath model: lane add in mode 0; in mode 3 each lane folds
  // its two signed 16-bit halves together and adds operand b.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      if (add_mode3_o)
        add_sum_i[k] = {{16{add_a_o[k][15]}}, add_a_o[k][15:0]}
                     + {{16{add_a_o[k][31]}}, add_a_o[k][31:16]} + add_b_o[k];
      else
        add_sum_i[k] = add_a_o[k] + add_b_o[k];
    end
  end

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_o); end
    checks++; if (op_ready_o !== 1'b0 || res_valid_o !== 1'b0 || add_mode3_o !== 1'b0) begin
      errors++; $display("FAIL rst_ctrl got rdy=%b vld=%b m3=%b exp 0", op_ready_o, res_valid_o, add_mode3_o); end
    checks++; if (add_a_o !== '0 || add_b_o !== '0 || res_data_o !== '0) begin
      errors++; $display("FAIL rst_data got a=%h b=%h r=%h exp 0", add_a_o, add_b_o, res_data_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [1:0][31:0] beats [3];
    int hs;
    beats[0] = {32'd2, 32'd1};
    beats[1] = {32'd20, 32'd10};
    beats[2] = {32'd200, 32'd100};
    hs = 0;
    @(negedge clk_i);
    start_i = 1'b1; len_i = 16'd3; mode3_i = 1'b0; keep_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      start_i = 1'b0; op_valid_i = 1'b1; op_data_i = beats[i];
      #1;
      if (op_ready_o === 1'b1) hs++;
    end
    @(negedge clk_i);
    op_valid_i = 1'b0;
    #1;
    if (op_ready_o === 1'b1) hs++;
    checks++; if (hs !== 3) begin errors++; $display("FAIL b2b_ready_cycles got %0d exp 3", hs); end
    checks++; if (res_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_latency got %b exp 1", res_valid_o); end
    checks++; if (res_data_o !== {32'd222, 32'd111}) begin errors++; $display("FAIL b2b_res got %h exp %h", res_data_o, {32'd222, 32'd111}); end
    checks++; if (add_a_o !== '0 || add_b_o !== '0) begin errors++; $display("FAIL b2b_dp_quiet got a=%h b=%h exp 0", add_a_o, add_b_o); end
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", busy_o); end
  endtask

  task automatic test_chain;
    @(negedge clk_i);
    start_i = 1'b1; len_i = 16'd1; mode3_i = 1'b0; keep_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; op_valid_i = 1'b1; op_data_i = {32'd5, 32'd5};
    @(negedge clk_i);
    op_valid_i = 1'b0;
    #1;
    checks++; if (res_data_o !== {32'd227, 32'd116} || res_valid_o !== 1'b1) begin
      errors++; $display("FAIL chain_keep got v=%b %h exp 1 %h", res_valid_o, res_data_o, {32'd227, 32'd116}); end
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
    start_i = 1'b1; len_i = 16'd0; mode3_i = 1'b0; keep_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    checks++; if (res_valid_o !== 1'b1 || res_data_o !== '0) begin
      errors++; $display("FAIL chain_len0 got v=%b %h exp 1 0", res_valid_o, res_data_o); end
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
  endtask

  task automatic test_gapped;
    logic [1:0][31:0] beats [5];
    logic             vld [5];
    beats[0] = {32'd2, 32'd1};   vld[0] = 1'b1;
    beats[1] = {32'hDEAD, 32'hBEEF}; vld[1] = 1'b0;
    beats[2] = {32'h1234, 32'h5678}; vld[2] = 1'b0;
    beats[3] = {32'd20, 32'd10}; vld[3] = 1'b1;
    beats[4] = {32'd200, 32'd100}; vld[4] = 1'b1;
    @(negedge clk_i);
    start_i = 1'b1; len_i = 16'd3; mode3_i = 1'b0; keep_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      start_i = 1'b0; op_valid_i = vld[i]; op_data_i = beats[i];
      #1;
      if (i == 1 || i == 2) begin
        checks++; if (add_a_o !== {32'd2, 32'd1}) begin errors++; $display("FAIL gap_hold%0d got %h exp %h", i, add_a_o, {32'd2, 32'd1}); end
      end
    end
    @(negedge clk_i);
    op_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (res_valid_o !== 1'b1 || busy_o !== 1'b1 || res_data_o !== {32'd222, 32'd111}) begin
        errors++; $display("FAIL gap_stall%0d got v=%b busy=%b %h exp 1 1 %h", i, res_valid_o, busy_o, res_data_o, {32'd222, 32'd111}); end
      @(negedge clk_i);
    end
    // start in the acknowledge cycle must be ignored
    res_ready_i = 1'b1; start_i = 1'b1; len_i = 16'd0; mode3_i = 1'b0;
    @(negedge clk_i);
    res_ready_i = 1'b0; start_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL done_start_ignored got busy=%b exp 0", busy_o); end
  endtask

  task automatic test_fold;
    @(negedge clk_i);
    start_i = 1'b1; len_i = 16'd1; mode3_i = 1'b1; keep_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0; op_valid_i = 1'b1; op_data_i = {32'h0003_0004, 32'h0001_0002};
    @(negedge clk_i);
    op_valid_i = 1'b0;
    #1;
    checks++; if (add_mode3_o !== 1'b1 || add_b_o !== '0 || op_ready_o !== 1'b0 || res_valid_o !== 1'b0) begin
      errors++; $display("FAIL fold_cycle got m3=%b b=%h rdy=%b v=%b exp 1 0 0 0", add_mode3_o, add_b_o, op_ready_o, res_valid_o); end
    checks++; if (add_a_o !== {32'h0003_0004, 32'h0001_0002}) begin
      errors++; $display("FAIL fold_a got %h exp %h", add_a_o, {32'h0003_0004, 32'h0001_0002}); end
    @(negedge clk_i);
    #1;
    checks++; if (res_valid_o !== 1'b1 || res_data_o !== {32'd7, 32'd3}) begin
      errors++; $display("FAIL fold_res got v=%b %h exp 1 %h", res_valid_o, res_data_o, {32'd7, 32'd3}); end
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
    // len=0 with fold: two-cycle latency, accumulators (3,7) kept
    start_i = 1'b1; len_i = 16'd0; mode3_i = 1'b1; keep_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    checks++; if (res_valid_o !== 1'b0 || add_mode3_o !== 1'b1) begin
      errors++; $display("FAIL fold_len0_c1 got v=%b m3=%b exp 0 1", res_valid_o, add_mode3_o); end
    @(negedge clk_i);
    #1;
    checks++; if (res_valid_o !== 1'b1 || res_data_o !== {32'd7, 32'd3}) begin
      errors++; $display("FAIL fold_len0_res got v=%b %h exp 1 %h", res_valid_o, res_data_o, {32'd7, 32'd3}); end
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
  endtask

  task automatic test_wrap;
    @(negedge clk_i);
    start_i = 1'b1; len_i = 16'd2; mode3_i = 1'b0; keep_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0; op_valid_i = 1'b1; op_data_i = {32'd1, 32'hFFFF_FFFF};
    @(negedge clk_i);
    op_data_i = {32'hFFFF_FFFF, 32'd1};
    #1;
    checks++; if (add_a_o !== {32'd1, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL wrap_mid got %h exp %h", add_a_o, {32'd1, 32'hFFFF_FFFF}); end
    @(negedge clk_i);
    op_valid_i = 1'b0;
    #1;
    checks++; if (res_valid_o !== 1'b1 || res_data_o !== '0) begin
      errors++; $display("FAIL wrap_res got v=%b %h exp 1 0", res_valid_o, res_data_o); end
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
  endtask

  task automatic test_abort_reset;
    @(negedge clk_i);
    start_i = 1'b1; len_i = 16'd4; mode3_i = 1'b0; keep_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0; op_valid_i = 1'b1; op_data_i = {32'd1, 32'd1};
    @(negedge clk_i);
    op_data_i = {32'd2, 32'd2};
    @(negedge clk_i);
    op_data_i = {32'd4, 32'd4}; abort_i = 1'b1;
    #1;
    checks++; if (op_ready_o !== 1'b0) begin errors++; $display("FAIL abort_ready got %b exp 0", op_ready_o); end
    @(negedge clk_i);
    abort_i = 1'b0; op_valid_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || res_valid_o !== 1'b0) begin
      errors++; $display("FAIL abort_idle got busy=%b v=%b exp 0 0", busy_o, res_valid_o); end
    // keep=1, len=0 exposes the accumulators after the abort
    start_i = 1'b1; len_i = 16'd0; mode3_i = 1'b0; keep_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    checks++; if (res_valid_o !== 1'b1 || res_data_o !== '0) begin
      errors++; $display("FAIL abort_acc got v=%b %h exp 1 0", res_valid_o, res_data_o); end
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
    start_i = 1'b1; len_i = 16'd4; keep_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0; op_valid_i = 1'b1; op_data_i = {32'd7, 32'd7};
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || op_ready_o !== 1'b0 || res_valid_o !== 1'b0 || add_mode3_o !== 1'b0) begin
      errors++; $display("FAIL async_rst_ctrl got busy=%b rdy=%b v=%b m3=%b exp 0", busy_o, op_ready_o, res_valid_o, add_mode3_o); end
    checks++; if (add_a_o !== '0 || add_b_o !== '0 || res_data_o !== '0) begin
      errors++; $display("FAIL async_rst_data got a=%h b=%h r=%h exp 0", add_a_o, add_b_o, res_data_o); end
    op_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    start_i = 1'b1; len_i = 16'd0; mode3_i = 1'b0; keep_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    checks++; if (res_valid_o !== 1'b1 || res_data_o !== '0) begin
      errors++; $display("FAIL rst_acc got v=%b %h exp 1 0", res_valid_o, res_data_o); end
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_chain();
    test_gapped();
    test_fold();
    test_wrap();
    test_abort_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mp_acc_seq.md
Name: mp_acc_seq

Overview:
- Sequencer that owns the shared two-lane packed-add datapath (p_a/p_b/mode_3 → sums) and uses it to accumulate a stream of operand-word pairs into two 32-bit accumulators.
- When the command requests it, the block adds a final mode_3 fold pass.
- It sits between the mixed-precision MAC front end, which supplies the operand stream, and the core-side result consumer.
- The datapath is external and combinational: the sequencer drives it and writes sums back into its own accumulator registers.

Parameters:
CNT_W, 16, width of beat-count field len_i and internal remaining-beat counter

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  command strobe; accepted only when busy_o=0
len_i  input  CNT_W  number of operand beats in the command
mode3_i  input  1  run the fold pass after the last beat
keep_i  input  1  1: start from current accumulators; 0: clear them at start
abort_i  input  1  cancel the in-flight command
busy_o  output  1  high in every state except IDLE
op_valid_i  input  1  operand beat valid
op_ready_o  output  1  operand beat ready
op_data_i  input  32 x [2]  operand words, lane 0/1
add_a_o  output  32 x [2]  datapath operand a
add_b_o  output  32 x [2]  datapath operand b
add_mode3_o  output  1  datapath mode_3 select
add_sum_i  input  32 x [2]  datapath sums
res_valid_o  output  1  result valid
res_ready_i  input  1  result accepted
res_data_o  output  32 x [2]  result lanes

Behaviour:
- Reset values: state IDLE; acc[0..1]=0; counter=0; busy_o, op_ready_o, res_valid_o, add_mode3_o all 0; add_a_o, add_b_o and res_data_o all zero.
- Reset may assert in any state, mid-command included. The block returns to these values immediately, with no further datapath writes.
- States are IDLE, RUN, FOLD and DONE.
- IDLE:
  - On start_i: latch len_i and mode3_i, and clear acc if keep_i=0.
  - If len_i≠0, go to RUN with counter=len_i.
  - If len_i=0, go to FOLD when mode3_i=1, otherwise DONE.
  - start_i is ignored while busy_o=1.
- RUN:
  - op_ready_o=1, add_a_o=acc, add_b_o=op_data_i, add_mode3_o=0.
  - On a handshake (op_valid_i & op_ready_o): acc[k] <= add_sum_i[k] and the counter decrements.
  - Throughput is one beat per cycle; no bubbles are inserted.
  - On the beat where the counter goes 1→0, the next state is FOLD if mode3 is latched, otherwise DONE.
  - While op_valid_i=0, the accumulators hold.
- FOLD (exactly 1 cycle):
  - add_a_o=acc, add_b_o=0, add_mode3_o=1, op_ready_o=0.
  - acc[k] <= add_sum_i[k]; this is the sign-extended field pair produced by the datapath. Then go to DONE.
- DONE:
  - res_valid_o=1 and res_data_o=acc; both hold stable until res_ready_i.
  - On res_ready_i, go to IDLE next cycle. The accumulators are retained so a later keep_i=1 command can chain.
  - If start_i arrives in the same cycle it is ignored, because busy_o is still 1.
- Datapath outputs are all zero whenever the state is IDLE or DONE.
- abort_i:
  - In RUN or FOLD: go to IDLE next cycle and clear acc.
  - A beat presented in the same cycle is not consumed (op_ready_o is forced 0 when abort_i=1).
  - abort_i is ignored in IDLE and DONE.
- Arithmetic: the sequencer applies no arithmetic of its own. Datapath sums are taken as 32-bit values, and wrap-around is the datapath's modular behaviour in mode_3=0.
- Latency from last beat to res_valid_o: 1 cycle (mode3=0) or 2 cycles (mode3=1).
- Latency from start_i with len_i=0 to res_valid_o: 1 cycle (mode3=0) or 2 cycles (mode3=1).
- Counter width is CNT_W. The largest command is len_i = 2^CNT_W − 1 beats.

Test Plan:
1. Reset, then start len=3, mode3=0, keep=0; beats (1,2),(10,20),(100,200) back-to-back → res_valid_o 1 cycle after 3rd beat, res=(111,222); op_ready_o high exactly 3 handshake cycles.
2. Same command with op_valid_i gapped (valid on cycles 0,3,4) → identical result; acc unchanged during gaps; res_ready_i held low 5 cycles → res_data_o stable, busy_o=1 throughout.
3. Start len=1, mode3=1 with beat (32'h0001_0002, 32'h0003_0004) → one FOLD cycle with add_mode3_o=1, add_b_o=0, then res_data_o equals the datapath mode_3 output for acc=(32'h0001_0002, 32'h0003_0004).
4. Chaining: after test 1 completes, start len=1, keep=1, beat (5,5) → res=(116,227); then len=0, keep=0, mode3=0 → res=(0,0) one cycle after start.
5. Wrap: keep=0, beats (32'hFFFF_FFFF,1),(1,32'hFFFF_FFFF) → res=(0,0).
6. Abort after 2 of 4 beats with op_valid_i high in the abort cycle → beat not consumed, IDLE next cycle, acc=0, no res_valid_o; then deassert rst_ni mid-RUN of a new command → all outputs at reset values asynchronously.
